// File: rtl/switch_activity_monitor.sv
// switch_activity_monitor: counts toggles per probed net over fixed
// windows of 2^WIN_LOG2 comparisons. At each window end it reports the
// total and peak over a valid/ready handshake.
// Optional macro SWITCH_ACT_PEAK_EN builds the peak search. Without it,
// peak_cnt and peak_idx are tied to 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              monitor enable; low aborts the current window
//   probe           nets under observation (synchronous to clk)
//   out_valid/ready result handshake
//   total_cnt       sum of the per-net counts for the window
//   peak_cnt/idx    largest per-net count, lowest index on ties
//   overrun         sticky: a window result was dropped
// The result registers load on the window-end edge, so out_valid
// rises on the cycle after the last comparison.
module switch_activity_monitor #(
  parameter int NUM_SIG  = 4,
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_SIG-1:0]               probe,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_W+$clog2(NUM_SIG)-1:0] total_cnt,
  output logic [CNT_W-1:0]                 peak_cnt,
  output logic [$clog2(NUM_SIG)-1:0]       peak_idx,
  output logic                             overrun
);

  localparam int IDX_W = $clog2(NUM_SIG);
  localparam int TOT_W = CNT_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    COUNT
  } state_t;

  state_t              r_state;
  logic [NUM_SIG-1:0]  r_prev;
  logic [CNT_W-1:0]    r_cnt [NUM_SIG];
  logic [WIN_LOG2-1:0] r_win;

  logic [NUM_SIG-1:0]  w_tog;
  logic [CNT_W-1:0]    w_nxt [NUM_SIG];
  logic [TOT_W-1:0]    w_total;
  logic [CNT_W-1:0]    w_pk_cnt;
  logic [IDX_W-1:0]    w_pk_idx;
  logic                w_win_end;
  logic                w_load;

  assign w_tog     = probe ^ r_prev;
  assign w_win_end = (r_win == '1);
  // A result may load if the slot is empty or is being emptied now.
  assign w_load    = !out_valid || out_ready;

  // Next counts include this cycle's comparison, so the window-end
  // result covers all W comparisons.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      w_nxt[i] = r_cnt[i];
      if (w_tog[i] && (r_cnt[i] != '1))
        w_nxt[i] = r_cnt[i] + CNT_W'(1);
      w_total = w_total + TOT_W'(w_nxt[i]);
    end
  end

`ifdef SWITCH_ACT_PEAK_EN
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_pk_cnt = '0;
    w_pk_idx = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      if (w_nxt[i] > w_pk_cnt) begin
        w_pk_cnt = w_nxt[i];
        w_pk_idx = IDX_W'(i);
      end
    end
  end
`else
  assign w_pk_cnt = '0;
  assign w_pk_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prev    <= '0;
      r_win     <= '0;
      for (int i = 0; i < NUM_SIG; i++)
        r_cnt[i] <= '0;
      out_valid <= 1'b0;
      total_cnt <= '0;
      peak_cnt  <= '0;
      peak_idx  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en)
            r_state <= PRIME;
        end
        PRIME: begin
          if (!en) begin
            r_state <= IDLE;
          end else begin
            r_prev  <= probe;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (!en) begin
            // Abort: partial counts are dropped.
            r_state <= IDLE;
            r_win   <= '0;
            for (int i = 0; i < NUM_SIG; i++)
              r_cnt[i] <= '0;
          end else begin
            r_prev <= probe;
            r_win  <= r_win + WIN_LOG2'(1);
            if (w_win_end) begin
              for (int i = 0; i < NUM_SIG; i++)
                r_cnt[i] <= '0;
              if (w_load) begin
                out_valid <= 1'b1;
                total_cnt <= w_total;
                peak_cnt  <= w_pk_cnt;
                peak_idx  <= w_pk_idx;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              for (int i = 0; i < NUM_SIG; i++)
                r_cnt[i] <= w_nxt[i];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_activity_monitor.sv
// tb_switch_activity_monitor: scoreboard bench for the toggle monitor.
// Expected window results are queued and compared on each handshake.
module tb_switch_activity_monitor;

`ifdef SWITCH_ACT_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  probe = 4'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [17:0] total_cnt;
  logic [15:0] peak_cnt;
  logic [1:0]  peak_idx;
  logic        overrun;

  logic        s_en = 1'b0;
  logic [3:0]  s_probe = 4'b0;
  logic        s_ready = 1'b1;
  logic        s_valid;
  logic [3:0]  s_total;
  logic [1:0]  s_peak;
  logic [1:0]  s_idx;
  logic        s_ovr;

  typedef struct packed {
    logic [17:0] tot;
    logic [15:0] pk;
    logic [1:0]  idx;
  } res_t;

  res_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  switch_activity_monitor #(
    .NUM_SIG(4), .CNT_W(16), .WIN_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .probe(probe),
    .out_valid(out_valid), .out_ready(out_ready),
    .total_cnt(total_cnt), .peak_cnt(peak_cnt),
    .peak_idx(peak_idx), .overrun(overrun)
  );

  switch_activity_monitor #(
    .NUM_SIG(4), .CNT_W(2), .WIN_LOG2(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(s_en), .probe(s_probe),
    .out_valid(s_valid), .out_ready(s_ready),
    .total_cnt(s_total), .peak_cnt(s_peak),
    .peak_idx(s_idx), .overrun(s_ovr)
  );

  function automatic void push(input int t, input int p, input int i);
    res_t r;
    r.tot = 18'(t);
    r.pk  = PEAK ? 16'(p) : 16'd0;
    r.idx = PEAK ? 2'(i) : 2'd0;
    q.push_back(r);
  endfunction

  // One clock: pop/compare on a mid-cycle handshake, then step to
  // 1 time unit after the next rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got total=%0d, none expected",
                 total_cnt);
      end else begin
        e = q.pop_front();
        if (total_cnt !== e.tot || peak_cnt !== e.pk ||
            peak_idx !== e.idx) begin
          n_err++;
          $display("FAIL result: got %0d/%0d/%0d want %0d/%0d/%0d",
                   total_cnt, peak_cnt, peak_idx, e.tot, e.pk, e.idx);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_win();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic cmp(input logic [3:0] m);
    probe = probe ^ m;
    tick();
  endtask

  task automatic stop();
    en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({out_valid, total_cnt, peak_cnt, peak_idx, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b t=%0d p=%0d i=%0d o=%b want 0",
               out_valid, total_cnt, peak_cnt, peak_idx, overrun);
    end
    rst = 1'b0;
    probe = 4'b1010;
    for (int j = 0; j < 10; j++) begin
      probe = ~probe;
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_result: got %b want 0", out_valid);
    end
  endtask

  task automatic check_drained(input string nm);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d pending want 0", nm, q.size());
    end
  endtask

  task automatic test_constant();
    out_ready = 1'b1;
    probe = 4'b0;
    push(0, 0, 0);
    start_win();
    for (int j = 0; j < 8; j++) begin
      cmp(4'b0000);
      if (j == 6) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL const_early_valid: got %b want 0", out_valid);
        end
      end
      if (j == 7) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL const_valid: got %b want 1", out_valid);
        end
      end
    end
    stop();
    check_drained("const");
  endtask

  task automatic test_fast();
    push(8, 8, 2);
    push(8, 8, 2);
    start_win();
    for (int j = 0; j < 16; j++) begin
      cmp(4'b0100);
      if (j == 7 || j == 15) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL fast_valid_%0d: got %b want 1", j, out_valid);
        end
      end
      if (j == 8) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL fast_valid_fall: got %b want 0", out_valid);
        end
      end
    end
    stop();
    check_drained("fast");
  endtask

  task automatic test_mix();
    logic [3:0] m;
    push(10, 4, 1);
    start_win();
    for (int j = 0; j < 8; j++) begin
      m = 4'b0;
      if (j % 2 == 1) m = m | 4'b1010;
      if (j % 4 == 3) m = m | 4'b0001;
      cmp(m);
    end
    stop();
    check_drained("mix");
  endtask

  task automatic test_random();
    logic [3:0] ms [8];
    int cnt [4];
    int tot, pk, pi;
    start_win();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int j = 0; j < 8; j++) begin
        ms[j] = 4'($urandom);
        for (int i = 0; i < 4; i++)
          if (ms[j][i]) cnt[i]++;
      end
      tot = 0;
      pk = 0;
      pi = 0;
      for (int i = 0; i < 4; i++) begin
        tot += cnt[i];
        if (cnt[i] > pk) begin
          pk = cnt[i];
          pi = i;
        end
      end
      push(tot, pk, pi);
      for (int j = 0; j < 8; j++) cmp(ms[j]);
    end
    stop();
    check_drained("random");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(8, 8, 2);
    start_win();
    for (int j = 0; j < 8; j++) cmp(4'b0100);
    n_vec++;
    if (out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL bp_first: got v=%b o=%b want v=1 o=0",
               out_valid, overrun);
    end
    for (int j = 0; j < 8; j++) cmp(4'b0011);
    n_vec++;
    if (out_valid !== 1'b1 || overrun !== 1'b1 || total_cnt !== 18'd8) begin
      n_err++;
      $display("FAIL bp_hold: got v=%b o=%b t=%0d want v=1 o=1 t=8",
               out_valid, overrun, total_cnt);
    end
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got v=%b o=%b want v=0 o=1",
               out_valid, overrun);
    end
    tick();
    check_drained("bp");
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    start_win();
    for (int j = 0; j < 4; j++) cmp(4'b1111);
    en = 1'b0;
    probe = probe ^ 4'b1111;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_valid: got %b want 0", out_valid);
    end
    push(8, 8, 0);
    start_win();
    for (int j = 0; j < 8; j++) cmp(4'b0001);
    stop();
    check_drained("abort");
    start_win();
    for (int j = 0; j < 7; j++) cmp(4'b0100);
    en = 1'b0;
    probe = probe ^ 4'b0100;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_at_end: got %b want 0", out_valid);
    end
    tick();
    check_drained("abort_end");
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    start_win();
    for (int j = 0; j < 11; j++) cmp(4'b0100);
    rst = 1'b1;
    en = 1'b0;
    tick();
    n_vec++;
    if ({out_valid, total_cnt, peak_cnt, peak_idx, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b t=%0d p=%0d i=%0d o=%b want 0",
               out_valid, total_cnt, peak_cnt, peak_idx, overrun);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    push(8, 8, 2);
    start_win();
    for (int j = 0; j < 8; j++) cmp(4'b0100);
    stop();
    check_drained("reset_mid");
  endtask

  task automatic test_saturation();
    s_ready = 1'b1;
    s_en = 1'b1;
    tick();
    tick();
    for (int j = 0; j < 8; j++) begin
      s_probe = s_probe ^ 4'b0001;
      tick();
    end
    n_vec++;
    if (s_valid !== 1'b1 || s_total !== 4'd3 ||
        s_peak !== (PEAK ? 2'd3 : 2'd0) || s_idx !== 2'd0) begin
      n_err++;
      $display("FAIL saturation: got v=%b t=%0d p=%0d i=%0d want 1/3/%0d/0",
               s_valid, s_total, s_peak, s_idx, PEAK ? 3 : 0);
    end
    s_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_constant();
    test_fast();
    test_mix();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
